controller: RTL

Moore-style control unit for the 16-bit processor: it sequences fetch, decode and execute across the program counter, instruction register, data memory, register file and ALU. It sits inside `processor` beside the datapath. It reads only the instruction-register contents and drives every datapath control line. It also exports its current state encoding, which the board top level shows on HEX4.

---
 rtl/proc_pkg.sv | 36 +++
 rtl/controller.sv | 119 +++++++++++
 2 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit processor: instruction format, opcodes,
// controller state encodings and ALU function codes.
package proc_pkg;

  localparam int unsigned IR_W      = 16;
  localparam int unsigned OP_W      = 4;
  localparam int unsigned STATE_W   = 4;
  localparam int unsigned ALU_W     = 3;
  localparam int unsigned D_ADDR_W  = 8;
  localparam int unsigned RF_ADDR_W = 4;

  localparam logic [OP_W-1:0] OP_NOOP  = 4'h0;
  localparam logic [OP_W-1:0] OP_STORE = 4'h1;
  localparam logic [OP_W-1:0] OP_LOAD  = 4'h2;
  localparam logic [OP_W-1:0] OP_ADD   = 4'h3;
  localparam logic [OP_W-1:0] OP_SUB   = 4'h4;
  localparam logic [OP_W-1:0] OP_HALT  = 4'h5;

  typedef enum logic [STATE_W-1:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOADA  = 4'd4,
    S_LOADB  = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_e;

  localparam logic [ALU_W-1:0] ALU_ZERO = 3'd0;
  localparam logic [ALU_W-1:0] ALU_ADD  = 3'd1;
  localparam logic [ALU_W-1:0] ALU_SUB  = 3'd2;

endpackage

// File: rtl/controller.sv
// Moore control unit: sequences fetch/decode/execute and drives every
// datapath control line from the state register and the instruction register.
module controller
  import proc_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic [IR_W-1:0]      IR,
  output logic                 PC_clr,
  output logic                 PC_up,
  output logic                 IR_ld,
  output logic [D_ADDR_W-1:0]  D_addr,
  output logic                 D_wr,
  output logic                 RF_s,
  output logic [RF_ADDR_W-1:0] RF_W_addr,
  output logic                 RF_W_en,
  output logic [RF_ADDR_W-1:0] RF_Ra_addr,
  output logic [RF_ADDR_W-1:0] RF_Rb_addr,
  output logic [ALU_W-1:0]     ALU_s0,
  output logic [STATE_W-1:0]   state_o
);

  state_e              state;
  state_e              state_next;
  logic [OP_W-1:0]     opcode;

  assign opcode  = IR[15:12];
  assign state_o = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_INIT;
    else        state <= state_next;
  end

  // Next state and Moore outputs; everything idles at zero unless the state asks.
  always_comb begin
    state_next = state;
    PC_clr     = 1'b0;
    PC_up      = 1'b0;
    IR_ld      = 1'b0;
    D_addr     = '0;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = '0;
    RF_W_en    = 1'b0;
    RF_Ra_addr = '0;
    RF_Rb_addr = '0;
    ALU_s0     = ALU_ZERO;

    case (state)
      S_INIT: begin
        PC_clr     = 1'b1;
        state_next = S_FETCH;
      end
      S_FETCH: begin
        IR_ld      = 1'b1;
        PC_up      = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        // Pre-address the synchronous data memory so LoadB sees the read data.
        if (opcode == OP_LOAD) D_addr = IR[11:4];
        case (opcode)
          OP_NOOP:  state_next = S_NOOP;
          OP_STORE: state_next = S_STORE;
          OP_LOAD:  state_next = S_LOADA;
          OP_ADD:   state_next = S_ADD;
          OP_SUB:   state_next = S_SUB;
          OP_HALT:  state_next = S_HALT;
          default:  state_next = S_NOOP;
        endcase
      end
      S_NOOP: begin
        state_next = S_FETCH;
      end
      S_LOADA: begin
        D_addr     = IR[11:4];
        RF_s       = 1'b1;
        state_next = S_LOADB;
      end
      S_LOADB: begin
        D_addr     = IR[11:4];
        RF_s       = 1'b1;
        RF_W_addr  = IR[3:0];
        RF_W_en    = 1'b1;
        state_next = S_FETCH;
      end
      S_STORE: begin
        D_addr     = IR[7:0];
        RF_Ra_addr = IR[11:8];
        D_wr       = 1'b1;
        state_next = S_FETCH;
      end
      S_ADD: begin
        RF_Ra_addr = IR[11:8];
        RF_Rb_addr = IR[7:4];
        RF_W_addr  = IR[3:0];
        ALU_s0     = ALU_ADD;
        RF_W_en    = 1'b1;
        state_next = S_FETCH;
      end
      S_SUB: begin
        RF_Ra_addr = IR[11:8];
        RF_Rb_addr = IR[7:4];
        RF_W_addr  = IR[3:0];
        ALU_s0     = ALU_SUB;
        RF_W_en    = 1'b1;
        state_next = S_FETCH;
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: begin
        state_next = S_INIT;
      end
    endcase
  end

endmodule
